// File: rtl/vga_pkg.sv
// Shared VGA timing constants and derived boundaries for the sync, video-memory and colour stages.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   coord_t           10-bit pixel/line coordinate type
//   DEF_*             default 640x480@60 timing (pixels / lines), 100 MHz system clock
//   H_TOTAL, V_TOTAL  derived totals (800, 525)
//   H/V_SYNC_START/END derived sync pulse bounds (inclusive)
//   in_span()         inclusive range test used by the sync decoders
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] coord_t;

    // Default timing: 100 MHz system clock divided down to a 25 MHz pixel rate.
    localparam int DEF_CLK_DIV = 4;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;

    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Derived totals and sync bounds; every boundary is a sum of the segment widths.
    localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive range test on a coordinate.
    function automatic logic in_span(input coord_t pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle of VGA timing outputs: pixel strobe, position, blanking, syncs, frame marker.
// Latency: n/a (wires only).
// Backpressure: none; consumers sample position/video_on when pixel_tick=1.
//
// Signals:
//   pixel_tick    one-clk strobe, counters advance at the end of this cycle
//   pixel_x/y     current column / line
//   video_on      1 inside the visible area
//   hsync/vsync   active-low sync pulses
//   end_of_frame  one-clk pulse on the last pixel of a frame
// Modports: master (generator side, drives), slave (consumer side, samples).
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic   pixel_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   end_of_frame;

    modport master (
        output pixel_tick,
        output pixel_x,
        output pixel_y,
        output video_on,
        output hsync,
        output vsync,
        output end_of_frame
    );

    modport slave (
        input pixel_tick,
        input pixel_x,
        input pixel_y,
        input video_on,
        input hsync,
        input vsync,
        input end_of_frame
    );

endinterface

// File: rtl/pixel_tick_div.sv
// Mod-CLK_DIV counter producing a one-clk clock-enable strobe at the pixel rate.
// Latency: strobe is registered; first strobe on the CLK_DIV-th clk after reset release.
// Backpressure: none, free-running.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset (count=0, tick=0)
//   tick      registered strobe, high while the count sits at CLK_DIV-1
//   tick_nxt  value tick will take after the next edge (lets the parent
//             register tick-qualified outputs in step with tick itself)
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic tick_nxt
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_nxt;

    always_comb begin
        div_cnt_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        tick_nxt    = (div_cnt_nxt == LAST);
    end

    // tick is held in a flop so it is a clean decode of div_cnt==CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt_nxt;
            tick    <= tick_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel strobe, x/y position, video_on, hsync/vsync, end_of_frame.
// Latency: all outputs registered and mutually aligned (zero relative latency between them).
// Backpressure: none; consumers sample pixel_x/pixel_y/video_on when pixel_tick=1.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset; restarts the frame at (0,0)
//   vga    vga_sync_gen_if.master: pixel_tick, pixel_x, pixel_y, video_on,
//          hsync, vsync, end_of_frame
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_VIS   = DEF_H_VIS,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_VIS   = DEF_V_VIS,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic     clk,
    input  logic     reset,
    vga_sync_gen_if.master vga
);

    // Boundaries derived from the segment widths of this instance. Totals
    // must fit the 10-bit coordinates (<= 1024).
    localparam int LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_VIS + H_FP;
    localparam int HS_END      = HS_START + H_SYNC - 1;
    localparam int VS_START    = V_VIS + V_FP;
    localparam int VS_END      = VS_START + V_SYNC - 1;

    localparam coord_t X_LAST = coord_t'(LINE_LEN - 1);
    localparam coord_t Y_LAST = coord_t'(FRAME_LINES - 1);

    // Decoders shared by the reset and run branches so both stay consistent.
    function automatic logic vis_at(input coord_t x, input coord_t y);
        return (int'(x) < H_VIS) && (int'(y) < V_VIS);
    endfunction

    function automatic logic hs_at(input coord_t x);
        return !in_span(x, HS_START, HS_END);
    endfunction

    function automatic logic vs_at(input coord_t y);
        return !in_span(y, VS_START, VS_END);
    endfunction

    logic   tick;
    logic   tick_nxt;
    coord_t x_q;
    coord_t y_q;
    coord_t x_nxt;
    coord_t y_nxt;
    logic   line_end;
    logic   vis_q;
    logic   hs_q;
    logic   vs_q;
    logic   eof_q;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    // Next raster position: x advances on each tick, y on the tick that wraps x.
    always_comb begin
        line_end = (x_q == X_LAST);
        x_nxt    = x_q;
        y_nxt    = y_q;
        if (tick) begin
            x_nxt = line_end ? '0 : x_q + 1'b1;
            if (line_end) begin
                y_nxt = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end
        end
    end

    // Decoded outputs are computed from the next position, so once registered
    // they describe the same pixel as pixel_x/pixel_y in the same cycle.
    // end_of_frame uses tick_nxt for the same reason: it must coincide with
    // the tick that sits on the last pixel, not follow it.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            vis_q <= vis_at('0, '0);
            hs_q  <= hs_at('0);
            vs_q  <= vs_at('0);
            eof_q <= 1'b0;
        end else begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            vis_q <= vis_at(x_nxt, y_nxt);
            hs_q  <= hs_at(x_nxt);
            vs_q  <= vs_at(y_nxt);
            eof_q <= tick_nxt && (x_nxt == X_LAST) && (y_nxt == Y_LAST);
        end
    end

    assign vga.pixel_tick   = tick;
    assign vga.pixel_x      = x_q;
    assign vga.pixel_y      = y_q;
    assign vga.video_on     = vis_q;
    assign vga.hsync        = hs_q;
    assign vga.vsync        = vs_q;
    assign vga.end_of_frame = eof_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen with a reduced raster so several frames fit a short run.
// Expected state is derived from the clock count since the last reset with plain arithmetic.
// Reset pattern: initial reset, 3 free frames, one directed mid-frame reset, then random resets.
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int CD = 4;
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 30 pixels per line
    localparam int VT = VV + VF + VS + VB;   // 19 lines per frame
    localparam int FRAME = CD * HT * VT;     // 2280 clks per frame
    localparam int PHASE1_END = 3 + 3 * FRAME + 40;
    localparam int TOTAL_CYC  = PHASE1_END + 3 * FRAME + 3000;
    // Directed reset point: pixel (10,7) with divider phase 2.
    localparam int DIR_N = ((7 * HT) + 10) * CD + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .CLK_DIV (CD),
        .H_VIS   (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS   (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif.master)
    );

    typedef struct {
        int unsigned n;
        bit          first;
        logic        tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        hs;
        logic        vs;
        logic        eof;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   eof_cnt = 0;
    int unsigned last_eof_n = 0;

    // n = clocks elapsed since the cycle right after the last reset edge.
    function automatic exp_t model(input int unsigned n, input bit first);
        exp_t e;
        int unsigned p;
        int xi, yi;
        p  = n / CD;
        xi = int'(p % HT);
        yi = int'((p / HT) % VT);
        e.n     = n;
        e.first = first;
        e.tick  = ((n % CD) == CD - 1);
        e.x     = 10'(xi);
        e.y     = 10'(yi);
        e.von   = (xi < HV) && (yi < VV);
        e.hs    = !((xi >= HV + HF) && (xi < HV + HF + HS));
        e.vs    = !((yi >= VV + VF) && (yi < VV + VF + VS));
        e.eof   = e.tick && (xi == HT - 1) && (yi == VT - 1);
        return e;
    endfunction

    // Stimulus: drives reset and pushes the expected state for each cycle.
    initial begin
        int unsigned n;
        bit first;
        bit dir_done;
        n = 0;
        first = 1'b1;
        dir_done = 1'b0;
        reset = 1'b1;
        for (int cyc = 0; cyc < TOTAL_CYC; cyc++) begin
            @(posedge clk);
            if (reset) begin
                n = 0;
                if (cyc >= 3) first = 1'b0;
            end else begin
                n = n + 1;
            end
            q.push_back(model(n, first));
            #1;
            if (cyc < 2) begin
                reset = 1'b1;
            end else if (cyc < PHASE1_END) begin
                reset = 1'b0;
            end else if (!dir_done) begin
                reset = ((n % FRAME) == DIR_N);
                dir_done = reset;
            end else if (cyc < PHASE1_END + 2 * FRAME) begin
                reset = 1'b0;
            end else begin
                reset = ($urandom_range(0, 399) == 0);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (eof_cnt != 3) begin
            fails++;
            $display("FAIL eof_count: got %0d pulses in first 3 frames, expected 3", eof_cnt);
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scb_drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic d_von, d_hs, d_vs;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (vif.pixel_tick !== e.tick || vif.pixel_x !== e.x || vif.pixel_y !== e.y ||
                vif.video_on !== e.von || vif.hsync !== e.hs || vif.vsync !== e.vs ||
                vif.end_of_frame !== e.eof) begin
                fails++;
                $display("FAIL scb n=%0d: got tick=%b x=%0d y=%0d von=%b hs=%b vs=%b eof=%b, expected tick=%b x=%0d y=%0d von=%b hs=%b vs=%b eof=%b",
                         e.n, vif.pixel_tick, vif.pixel_x, vif.pixel_y, vif.video_on,
                         vif.hsync, vif.vsync, vif.end_of_frame,
                         e.tick, e.x, e.y, e.von, e.hs, e.vs, e.eof);
            end

            // Decode rules applied to whatever position the DUT presents.
            d_von = (int'(vif.pixel_x) < HV) && (int'(vif.pixel_y) < VV);
            d_hs  = !((int'(vif.pixel_x) >= HV + HF) && (int'(vif.pixel_x) < HV + HF + HS));
            d_vs  = !((int'(vif.pixel_y) >= VV + VF) && (int'(vif.pixel_y) < VV + VF + VS));
            checks++;
            if (vif.video_on !== d_von || vif.hsync !== d_hs || vif.vsync !== d_vs) begin
                fails++;
                $display("FAIL decode n=%0d at (%0d,%0d): got von=%b hs=%b vs=%b, expected von=%b hs=%b vs=%b",
                         e.n, vif.pixel_x, vif.pixel_y, vif.video_on, vif.hsync, vif.vsync,
                         d_von, d_hs, d_vs);
            end

            // Frame markers in the first three frames after the initial release.
            if (e.first && e.n < 3 * FRAME && vif.end_of_frame === 1'b1) begin
                if (eof_cnt > 0) begin
                    checks++;
                    if (e.n - last_eof_n != FRAME) begin
                        fails++;
                        $display("FAIL eof_gap: got %0d clks between pulses, expected %0d",
                                 e.n - last_eof_n, FRAME);
                    end
                end
                eof_cnt++;
                last_eof_n = e.n;
            end
        end
    end

endmodule
